center_seq_ctrl: RTL and testbench

Sequential controller for the row-mean centering step of the fetal-ECG ICA preprocessing chain.
- Accepts one SIZE_A x SIZE_B channel-by-sample matrix as a row-major stream and buffers it.
- Computes each row mean, then streams out every element minus its row mean.
- Sits between the sample acquisition buffer and the whitening/covariance stage; replaces the combinational centering path with a clocked, back-pressured one.

---
 rtl/center_pkg.sv | 11 +
 rtl/row_mean_unit.sv | 46 ++++
 rtl/center_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_center_seq_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/center_pkg.sv
// center_pkg: shared types, controller states and a width helper for center_seq_ctrl
package center_pkg;
  localparam int SAMPLE_W = 32;
  localparam int ACC_W_MAX = 64;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [ACC_W_MAX-1:0] acc_t;
  typedef enum logic [1:0] {IDLE, LOAD, MEAN, EMIT} ctrl_state_t;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/row_mean_unit.sv
// row_mean_unit: per-row signed accumulators and constant-divisor mean registers
//   i_clear            zero all row sums
//   i_acc_en/row/data  add one sample into sum[row]
//   i_div_en/i_div_row latch mean[row] = sum[row] / SIZE_B (truncating toward zero)
//   o_mean             registered row means
module row_mean_unit
  import center_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int DW = 32,
  parameter int R_W = clog2_min1(SIZE_A),
  parameter int ACC_W = DW + $clog2(SIZE_B) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clear,
  input  logic                 i_acc_en,
  input  logic [R_W-1:0]       i_acc_row,
  input  logic signed [DW-1:0] i_acc_data,
  input  logic                 i_div_en,
  input  logic [R_W-1:0]       i_div_row,
  output logic signed [DW-1:0] o_mean [SIZE_A]
);
  localparam logic signed [ACC_W-1:0] DIVISOR = ACC_W'(SIZE_B);
  logic signed [ACC_W-1:0] r_sum [SIZE_A];
  logic signed [DW-1:0] r_mean [SIZE_A];
  logic signed [ACC_W-1:0] w_quot;
  assign w_quot = r_sum[i_div_row] / DIVISOR;
  assign o_mean = r_mean;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SIZE_A; i++) begin
        r_sum[i] <= '0;
        r_mean[i] <= '0;
      end
    end else begin
      if (i_clear) begin
        for (int i = 0; i < SIZE_A; i++) r_sum[i] <= '0;
      end else if (i_acc_en) begin
        r_sum[i_acc_row] <= r_sum[i_acc_row] + ACC_W'(i_acc_data);
      end
      if (i_div_en) r_mean[i_div_row] <= w_quot[DW-1:0];
    end
  end
endmodule

// File: rtl/center_seq_ctrl.sv
// center_seq_ctrl: buffers a SIZE_A x SIZE_B matrix, then streams each element minus its row mean
//   start                      begin a matrix (IDLE only)
//   in_valid/in_ready/in_data  row-major input stream, accepted in LOAD
//   out_valid/out_ready        centered output stream with row/col tags
//   busy                       not IDLE; done pulses after the last output handshake
module center_seq_ctrl
  import center_pkg::*;
#(
  parameter int SIZE_A = 8,
  parameter int SIZE_B = 8,
  parameter int DW = 32,
  localparam int R_W = clog2_min1(SIZE_A),
  localparam int C_W = clog2_min1(SIZE_B)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [R_W-1:0]       out_row,
  output logic [C_W-1:0]       out_col,
  output logic                 busy,
  output logic                 done
);
  localparam int ACC_W = DW + $clog2(SIZE_B) + 1;
  localparam logic [R_W-1:0] LAST_R = R_W'(SIZE_A - 1);
  localparam logic [C_W-1:0] LAST_C = C_W'(SIZE_B - 1);
  ctrl_state_t r_state;
  logic [R_W-1:0] r_row;
  logic [C_W-1:0] r_col;
  logic r_emit_all;
  logic r_out_valid;
  logic r_done;
  logic signed [DW-1:0] r_out_data;
  logic [R_W-1:0] r_out_row;
  logic [C_W-1:0] r_out_col;
  logic signed [DW-1:0] r_buf [SIZE_A][SIZE_B];
  logic signed [DW-1:0] w_mean [SIZE_A];
  logic w_in_hs, w_last_r, w_last_c, w_fire, w_load;
  assign w_in_hs = in_valid && r_state == LOAD;
  assign w_last_r = r_row == LAST_R;
  assign w_last_c = r_col == LAST_C;
  assign w_fire = r_out_valid && out_ready;
  // the output register refills whenever it is empty or being drained this cycle
  assign w_load = r_state == EMIT && !r_emit_all && (!r_out_valid || out_ready);
  row_mean_unit #(
    .SIZE_A(SIZE_A), .SIZE_B(SIZE_B), .DW(DW), .R_W(R_W), .ACC_W(ACC_W)
  ) u_mean (
    .clk(clk),
    .rst_n(rst_n),
    .i_clear(r_state == IDLE && start),
    .i_acc_en(w_in_hs),
    .i_acc_row(r_row),
    .i_acc_data(in_data),
    .i_div_en(r_state == MEAN),
    .i_div_row(r_row),
    .o_mean(w_mean)
  );
  always_ff @(posedge clk) begin
    if (w_in_hs) r_buf[r_row][r_col] <= in_data;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_row <= '0;
      r_col <= '0;
      r_emit_all <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_state <= LOAD;
          r_row <= '0;
          r_col <= '0;
        end
        LOAD: if (in_valid) begin
          r_col <= w_last_c ? '0 : r_col + C_W'(1);
          if (w_last_c) begin
            r_row <= w_last_r ? '0 : r_row + R_W'(1);
            if (w_last_r) r_state <= MEAN;
          end
        end
        MEAN: begin
          r_row <= w_last_r ? '0 : r_row + R_W'(1);
          if (w_last_r) begin
            r_state <= EMIT;
            r_emit_all <= 1'b0;
          end
        end
        EMIT: begin
          if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data <= r_buf[r_row][r_col] - w_mean[r_row];
            r_out_row <= r_row;
            r_out_col <= r_col;
            r_col <= w_last_c ? '0 : r_col + C_W'(1);
            if (w_last_c) r_row <= w_last_r ? '0 : r_row + R_W'(1);
            if (w_last_c && w_last_r) r_emit_all <= 1'b1;
          end else if (w_fire) begin
            r_out_valid <= 1'b0;
          end
          if (w_fire && r_emit_all) begin
            r_state <= IDLE;
            r_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign in_ready = r_state == LOAD;
  assign busy = r_state != IDLE;
  assign out_valid = r_out_valid;
  assign out_data = r_out_data;
  assign out_row = r_out_row;
  assign out_col = r_out_col;
  assign done = r_done;
endmodule

// File: tb/tb_center_seq_ctrl.sv
// tb_center_seq_ctrl: scoreboard bench for center_seq_ctrl with a 2x4 matrix
module tb_center_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic signed [31:0] in_data, out_data;
  logic [0:0] out_row;
  logic [1:0] out_col;
  typedef struct {logic signed [31:0] d; int r; int c;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, n_pop = 0, t_last = 0;
  bit lat_armed = 0, bp = 0;
  logic signed [31:0] m1 [8] = '{1, 2, 3, 4, -1, -2, -3, -4};
  logic signed [31:0] m7 [8] = '{7, 7, 7, 7, 7, 7, 7, 7};
  logic signed [31:0] mx [8] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                                 32'h80000000, 0, 0, 0};
  center_seq_ctrl #(.SIZE_A(2), .SIZE_B(4), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  initial begin
    int ph = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ph = (ph + 1) % 3;
      out_ready = bp ? (ph == 0) : 1'b1;
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (in_valid && in_ready) begin
        t_last = cyc + 1;
        lat_armed = 1;
      end
      if (out_valid) begin
        if (lat_armed) begin
          chk("latency", cyc - t_last, 3);
          lat_armed = 0;
        end
        if (q.size() == 0) chk("extra_out", q.size(), 1);
        else begin
          chk("data", out_data, q[0].d);
          chk("row", out_row, q[0].r);
          chk("col", out_col, q[0].c);
          if (out_ready) begin
            void'(q.pop_front());
            n_pop++;
          end
        end
      end
    end
  end
  task automatic send(input logic signed [31:0] m [8], input bit gaps, input int st_at);
    longint s [2];
    exp_t e;
    s[0] = 0;
    s[1] = 0;
    for (int i = 0; i < 8; i++) s[i/4] += longint'(m[i]);
    for (int i = 0; i < 8; i++) begin
      e.d = 32'(longint'(m[i]) - s[i/4] / 4);
      e.r = i / 4;
      e.c = i % 4;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_load", busy, 1);
    for (int i = 0; i < 8; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data = m[i];
      start = (i == st_at);
      chk("in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("load_closed", in_ready, 0);
  endtask
  task automatic wait_done();
    int base;
    base = done_cnt;
    for (int k = 0; k < 200 && done_cnt == base; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt - base, 1);
    chk("drained", q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    int base;
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk) rst_n = 1'b1;
    send(m1, 0, -1);
    wait_done();
    bp = 1;
    send(m1, 0, -1);
    wait_done();
    bp = 0;
    send(m1, 1, -1);
    wait_done();
    send(m1, 0, 2);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1;
    chk("busy_emit", busy, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();
    send(m7, 0, -1);
    wait_done();
    base = n_pop;
    send(m1, 0, -1);
    for (int k = 0; k < 100 && n_pop < base + 3; k++) @(negedge clk);
    chk("pops_before_rst", n_pop - base, 3);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", in_ready, 0);
    q.delete();
    lat_armed = 0;
    @(negedge clk) rst_n = 1'b1;
    send(m1, 0, -1);
    wait_done();
    send(mx, 0, -1);
    wait_done();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
